// File: rtl/booth_mac_seq_ctrl.sv
// booth_mac_seq_ctrl
// Iterative signed 8x8 multiply-accumulate controller. One radix-4 Booth lane is
// summed per cycle into a 16-bit product. The product is then added into a
// persistent ACC_W-bit accumulator, and the result is returned over valid/ready.
// Optional feature macro: MAC_SAT_EN. When it is defined the accumulator
// saturates and out_sat is a sticky flag. When it is undefined the accumulator
// wraps and out_sat is tied to 0.
//
// state | meaning
// IDLE  | ready for an operand pair; out_acc holds the last result
// GEN   | add Booth lane pp[idx] into the product, one lane per cycle
// ACC   | fold the product into the accumulator and load the result registers
// RESP  | one settle cycle, then hold out_valid until the consumer takes it
module booth_mac_seq_ctrl #(
  parameter int ACC_W  = 24,
  parameter int NUM_PP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [15:0]      out_prod,
  output logic             out_sat
);

  typedef enum logic [1:0] {IDLE, GEN, ACC, RESP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic             clr_q, clr_d;
  logic [15:0]      prod_q, prod_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]      oprod_q, oprod_d;
  logic             ovld_q, ovld_d;
  logic [15:0]      lane;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_next;
`ifdef MAC_SAT_EN
  logic             sat_q, sat_d;
  logic [ACC_W:0]   acc_sum;
  logic             acc_ovf;
`endif

  // Weighted Booth partial product for one lane: the digit comes from the
  // triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1] = 0, and the result is
  // shifted by 4^i.
  function automatic logic [15:0] booth_pp(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] idx);
    logic [8:0]  bx;
    logic [8:0]  bsh;
    logic [15:0] ae;
    logic [15:0] m;
    bx  = {b, 1'b0};
    bsh = bx >> {idx, 1'b0};
    ae  = {{8{a[7]}}, a};
    case (bsh[2:0])
      3'b001, 3'b010: m = ae;
      3'b011:         m = ae << 1;
      3'b100:         m = -(ae << 1);
      3'b101, 3'b110: m = -ae;
      default:        m = 16'd0;
    endcase
    return m << {idx, 1'b0};
  endfunction

  // Accumulator update: the base is either zero (clear) or the running value.
  always_comb begin
    lane     = booth_pp(a_q, b_q, idx_q);
    acc_base = clr_q ? '0 : acc_q;
`ifdef MAC_SAT_EN
    acc_sum  = {acc_base[ACC_W-1], acc_base} + {{(ACC_W-15){prod_q[15]}}, prod_q};
    acc_ovf  = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
    if (!acc_ovf)
      acc_next = acc_sum[ACC_W-1:0];
    else if (acc_sum[ACC_W])
      acc_next = {1'b1, {(ACC_W-1){1'b0}}};
    else
      acc_next = {1'b0, {(ACC_W-1){1'b1}}};
`else
    acc_next = acc_base + {{(ACC_W-16){prod_q[15]}}, prod_q};
`endif
  end

  // Next-state and datapath updates for the sequencing FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    clr_d   = clr_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    oprod_d = oprod_q;
    ovld_d  = ovld_q;
`ifdef MAC_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          clr_d   = in_clr;
          prod_d  = 16'd0;
          idx_d   = 2'd0;
          state_d = GEN;
        end
      end
      GEN: begin
        prod_d = prod_q + lane;
        idx_d  = idx_q + 2'd1;
        if (idx_q == 2'(NUM_PP - 1))
          state_d = ACC;
      end
      ACC: begin
        acc_d   = acc_next;
        oprod_d = prod_q;
`ifdef MAC_SAT_EN
        sat_d   = clr_q ? acc_ovf : (sat_q | acc_ovf);
`endif
        state_d = RESP;
      end
      RESP: begin
        // The first RESP cycle only raises out_valid. After that, the result is
        // presented until the consumer accepts it.
        if (ovld_q && out_ready) begin
          ovld_d  = 1'b0;
          state_d = IDLE;
        end else begin
          ovld_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset is synchronous and overrides every transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      clr_q   <= 1'b0;
      prod_q  <= 16'd0;
      acc_q   <= '0;
      oprod_q <= 16'd0;
      ovld_q  <= 1'b0;
`ifdef MAC_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      clr_q   <= clr_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      oprod_q <= oprod_d;
      ovld_q  <= ovld_d;
`ifdef MAC_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ovld_q;
  assign out_acc   = acc_q;
  assign out_prod  = oprod_q;
`ifdef MAC_SAT_EN
  assign out_sat   = sat_q;
`else
  assign out_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mac_seq_ctrl.sv
// Directed testbench for booth_mac_seq_ctrl (ACC_W = 16). The expected values
// are hand-computed constants or plain a*b arithmetic.
module tb_booth_mac_seq_ctrl;

  localparam int ACC_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_clr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [15:0]      out_prod;
  logic             out_sat;

  int n_cmp = 0;
  int n_bad = 0;

  booth_mac_seq_ctrl #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_clr(in_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_prod(out_prod), .out_sat(out_sat)
  );

  // 10 ns clock period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one operand pair and return just after the accepting edge.
  task automatic start_op(input int a, input int b, input logic clr);
    chk("ready_before_op", in_ready, 1);
    in_a     = 8'(a);
    in_b     = 8'(b);
    in_clr   = clr;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 8'h5A;
    in_b     = 8'hA5;
  endtask

  // Count edges until out_valid is seen. The wait is bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    chk("valid_seen", out_valid, 1);
  endtask

  // A full op with out_ready held high: check the latency and the results,
  // then let the handshake edge pass.
  task automatic do_op(input string tag, input int a, input int b, input logic clr,
                       input longint exp_prod, input longint exp_acc);
    int lat;
    start_op(a, b, clr);
    wait_valid(lat);
    chk({tag, "_lat"}, lat, 6);
    chk({tag, "_prod"}, longint'($signed(out_prod)), exp_prod);
    chk({tag, "_acc"}, longint'($signed(out_acc)), exp_acc);
    @(posedge clk);
    #1;
    chk({tag, "_done"}, out_valid, 0);
  endtask

  initial begin : stim
    int sweep_v[10] = '{-128, -127, -64, -1, 0, 1, 2, 63, 85, 127};
    int lat;
    int rises;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 8'd0;
    in_b      = 8'd0;
    in_clr    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_prod", out_prod, 0);
    chk("rst_out_sat", out_sat, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic op, then the extreme operand pair and accumulation.
    do_op("t1", 3, 5, 1'b1, 15, 15);
    do_op("t2a", -128, -128, 1'b1, 16384, 16384);
    do_op("t2b", -128, 127, 1'b0, -16256, 128);

    // Operand sweep over boundary values with clear set.
    foreach (sweep_v[i])
      foreach (sweep_v[j])
        do_op("sweep", sweep_v[i], sweep_v[j], 1'b1,
              sweep_v[i] * sweep_v[j], sweep_v[i] * sweep_v[j]);

    // Backpressure: hold the result and ignore in_valid pulses.
    out_ready = 1'b0;
    start_op(10, -7, 1'b1);
    wait_valid(lat);
    chk("bp_lat", lat, 6);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      in_a     = 8'd1;
      in_b     = 8'd1;
      in_clr   = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_prod", longint'($signed(out_prod)), -70);
      chk("bp_acc", longint'($signed(out_acc)), -70);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_hs_valid", out_valid, 0);
    chk("bp_hs_ready", in_ready, 1);
    rises = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) rises++;
    end
    chk("bp_no_capture", rises, 0);
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_acc_hold", longint'($signed(out_acc)), -70);

    // Overflow at ACC_W = 16: 16129 three times.
`ifdef MAC_SAT_EN
    do_op("t5a", 127, 127, 1'b1, 16129, 16129);
    do_op("t5b", 127, 127, 1'b0, 16129, 32258);
    do_op("t5c", 127, 127, 1'b0, 16129, 32767);
    chk("t5_sat", out_sat, 1);
    do_op("t5d", 1, 1, 1'b0, 1, 32767);
    chk("t5_sat_sticky", out_sat, 1);
`else
    do_op("t5a", 127, 127, 1'b1, 16129, 16129);
    do_op("t5b", 127, 127, 1'b0, 16129, 32258);
    do_op("t5c", 127, 127, 1'b0, 16129, -17149);
    chk("t5_sat", out_sat, 0);
`endif
    do_op("t5e", 1, 1, 1'b1, 1, 1);
    chk("t5_sat_clr", out_sat, 0);

    // Reset in the middle of GEN, after two lanes have been summed.
    do_op("t6a", 20, 25, 1'b1, 500, 500);
    start_op(7, 9, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t6_in_ready", in_ready, 1);
    chk("t6_valid", out_valid, 0);
    chk("t6_acc", out_acc, 0);
    chk("t6_prod", out_prod, 0);
    chk("t6_sat", out_sat, 0);
    do_op("t6b", 2, -3, 1'b0, -6, -6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
